change_dispenser_ctrl: RTL and testbench

//  Sequences change return for the vending machine. It accepts a change amount in

---
 rtl/vm_pkg.sv | 34 +++
 rtl/coin_inventory.sv | 52 +++++
 rtl/change_dispenser_ctrl.sv | 156 +++++++++++++++
 tb/tb_change_dispenser_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denominations, their rupee values and
// the change-dispenser state encoding.
package vm_pkg;

   localparam int NUM_DEN = 5;

   typedef enum logic [2:0] {
      DEN_5   = 3'd0,
      DEN_10  = 3'd1,
      DEN_20  = 3'd2,
      DEN_50  = 3'd3,
      DEN_100 = 3'd4
   } den_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAN  = 3'd1,
      ST_EJECT = 3'd2,
      ST_GAP   = 3'd3,
      ST_FAULT = 3'd4
   } state_e;

   function automatic logic [6:0] den_val(input logic [2:0] idx);
      case (idx)
         DEN_5:   return 7'd5;
         DEN_10:  return 7'd10;
         DEN_20:  return 7'd20;
         DEN_50:  return 7'd50;
         DEN_100: return 7'd100;
         default: return 7'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin stock: saturating increment on deposit, decrement on eject,
// and a refill that loads every counter with its maximum.
module coin_inventory
   import vm_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int INIT_CNT = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            inc,
   input  logic [2:0]                      inc_sel,
   input  logic                            dec,
   input  logic [2:0]                      dec_sel,
   input  logic                            refill,
   output logic [NUM_DEN-1:0][CNT_W-1:0]   counts
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_DEN-1:0] inc_hit;
   logic [NUM_DEN-1:0] dec_hit;

   // NOTE: every combinational output gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      inc_hit = '0;
      dec_hit = '0;
      for (int i = 0; i < NUM_DEN; i++) begin
         inc_hit[i] = inc && (inc_sel == 3'(i));
         dec_hit[i] = dec && (dec_sel == 3'(i));
      end
   end

   // NOTE: the counter array is architectural state, so it is reset entry by
   // entry rather than left undefined like a scratch RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DEN; i++) counts[i] <= CNT_W'(INIT_CNT);
      end else begin
         for (int i = 0; i < NUM_DEN; i++) begin
            if (refill)
               counts[i] <= CNT_MAX;
            else if (inc_hit[i] && !dec_hit[i] && counts[i] != CNT_MAX)
               counts[i] <= counts[i] + 1'b1;
            else if (dec_hit[i] && !inc_hit[i])
               counts[i] <= counts[i] - 1'b1;
         end
      end
   end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change-return sequencer: greedy coin split against live stock, then one coin per
// valid/ack handshake to the eject mechanism, with a sticky timeout fault.
module change_dispenser_ctrl
   import vm_pkg::*;
#(
   parameter int AMT_W         = 9,
   parameter int CNT_W         = 4,
   parameter int INIT_CNT      = 4,
   parameter int EJECT_TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   input  logic [AMT_W-1:0]           req_amount,
   output logic                       req_ready,
   input  logic                       coin_in_vld,
   input  logic [2:0]                 coin_in_sel,
   input  logic                       refill,
   output logic                       eject_valid,
   output logic [2:0]                 eject_sel,
   input  logic                       eject_ack,
   output logic                       done,
   output logic                       fail,
   output logic                       fault,
   output logic [NUM_DEN*CNT_W-1:0]   inv_counts
);

   localparam int TMO_W = $clog2(EJECT_TIMEOUT + 1);

   state_e                        state_q, state_d;
   logic [AMT_W-1:0]              rem_q, quo, sub;
   logic [2:0]                    idx_q, ej_sel;
   logic [NUM_DEN-1:0][CNT_W-1:0] plan_q, stock;
   logic [CNT_W-1:0]              n_take;
   logic [TMO_W-1:0]              tmo_q;
   logic                          done_q, fail_q, done_d, fail_d;
   logic                          plan_any, ack_hit;

   assign plan_any = |plan_q;
   assign ack_hit  = (state_q == ST_EJECT) && eject_ack;

   // Constant divisor per denomination keeps the planner free of a real divider.
   always_comb begin
      quo = '0;
      for (int i = 0; i < NUM_DEN; i++)
         if (idx_q == 3'(i)) quo = rem_q / AMT_W'(den_val(3'(i)));
   end

   assign n_take = (quo > AMT_W'(stock[idx_q])) ? stock[idx_q] : quo[CNT_W-1:0];
   assign sub    = AMT_W'(n_take) * AMT_W'(den_val(idx_q));

   always_comb begin
      ej_sel = '0;
      for (int i = 0; i < NUM_DEN; i++)
         if (plan_q[i] != '0) ej_sel = 3'(i);
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_amount % AMT_W'(5) != '0) fail_d  = 1'b1;
               else                               state_d = ST_PLAN;
            end
         end
         ST_PLAN: begin
            if (idx_q == 3'(DEN_5)) begin
               if (rem_q != sub) begin
                  fail_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (plan_any || n_take != '0) begin
                  state_d = ST_EJECT;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_EJECT: begin
            if (eject_ack)                                state_d = ST_GAP;
            else if (tmo_q == TMO_W'(EJECT_TIMEOUT - 1)) state_d = ST_FAULT;
         end
         ST_GAP: begin
            if (plan_any) begin
               state_d = ST_EJECT;
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         idx_q   <= 3'(DEN_100);
         plan_q  <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         tmo_q   <= (state_q == ST_EJECT && !eject_ack) ? tmo_q + 1'b1 : '0;
         case (state_q)
            ST_IDLE: begin
               plan_q <= '0;
               rem_q  <= req_amount;
               idx_q  <= 3'(DEN_100);
            end
            ST_PLAN: begin
               plan_q[idx_q] <= n_take;
               rem_q         <= rem_q - sub;
               if (idx_q != 3'(DEN_5)) idx_q <= idx_q - 1'b1;
            end
            ST_EJECT: begin
               if (eject_ack) plan_q[ej_sel] <= plan_q[ej_sel] - 1'b1;
            end
            default: ;
         endcase
      end
   end

   coin_inventory #(
      .CNT_W    (CNT_W),
      .INIT_CNT (INIT_CNT)
   ) u_inventory (
      .clk     (clk),
      .rst     (rst),
      .inc     (coin_in_vld),
      .inc_sel (coin_in_sel),
      .dec     (ack_hit),
      .dec_sel (ej_sel),
      .refill  (refill && state_q == ST_IDLE),
      .counts  (stock)
   );

   assign req_ready   = (state_q == ST_IDLE);
   assign eject_valid = (state_q == ST_EJECT);
   assign eject_sel   = eject_valid ? ej_sel : 3'd0;
   assign done        = done_q;
   assign fail        = fail_q;
   assign fault       = (state_q == ST_FAULT);
   assign inv_counts  = stock;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench: directed scenarios plus randomized requests and coin traffic,
// checked against an arithmetic greedy-change and coin-stock model.
module tb_change_dispenser_ctrl;

   localparam int VAL [5] = '{5, 10, 20, 50, 100};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [8:0]  req_amount = '0;
   logic        req_ready;
   logic        coin_in_vld = 1'b0;
   logic [2:0]  coin_in_sel = '0;
   logic        refill = 1'b0;
   logic        eject_valid;
   logic [2:0]  eject_sel;
   logic        eject_ack = 1'b0;
   logic        done, fail, fault;
   logic [19:0] inv_counts;

   int n_cmp = 0;
   int n_bad = 0;
   int m_inv [5];

   change_dispenser_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_amount  (req_amount),
      .req_ready   (req_ready),
      .coin_in_vld (coin_in_vld),
      .coin_in_sel (coin_in_sel),
      .refill      (refill),
      .eject_valid (eject_valid),
      .eject_sel   (eject_sel),
      .eject_ack   (eject_ack),
      .done        (done),
      .fail        (fail),
      .fault       (fault),
      .inv_counts  (inv_counts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic logic [19:0] pack_inv();
      logic [19:0] r = '0;
      for (int i = 0; i < 5; i++) r[i*4 +: 4] = 4'(m_inv[i]);
      return r;
   endfunction

   // Stock rules: refill wins, deposit and eject of one denomination cancel,
   // deposits saturate at 15, out-of-range deposit indices are ignored.
   function automatic void model_apply(input bit inc, input int isel, input bit dec, input int dsel, input bit rf);
      if (rf) begin
         for (int i = 0; i < 5; i++) m_inv[i] = 15;
      end else if (!(inc && dec && isel == dsel)) begin
         if (inc && isel <= 4 && m_inv[isel] < 15) m_inv[isel]++;
         if (dec) m_inv[dsel]--;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit in_idle, input bit dec, input int dsel);
      model_apply(coin_in_vld, int'(coin_in_sel), dec, dsel, refill && in_idle);
      tick();
      coin_in_vld = 1'b0;
      refill      = 1'b0;
   endtask

   task automatic rand_coin();
      if ($urandom_range(0, 3) == 0) begin
         coin_in_vld = 1'b1;
         coin_in_sel = 3'($urandom_range(0, 7));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) m_inv[i] = 4;
      check("rst_req_ready", req_ready, 1);
      check("rst_eject_valid", eject_valid, 0);
      check("rst_eject_sel", eject_sel, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      check("rst_fault", fault, 0);
      check("rst_inv", inv_counts, 20'h44444);
      rst = 1'b0;
   endtask

   // One complete request; ack_dly<0 picks a random ack delay per coin,
   // force_sel>=0 deposits that denomination on every ack cycle.
   task automatic run_req(input int amount, input int ack_dly, input bit noisy, input int force_sel);
      int plan [5];
      int rem;
      int exp_q [$];
      int dly;
      rem = amount;
      for (int i = 4; i >= 0; i--) begin
         plan[i] = rem / VAL[i];
         if (plan[i] > m_inv[i]) plan[i] = m_inv[i];
         rem -= plan[i] * VAL[i];
         for (int k = 0; k < plan[i]; k++) exp_q.push_back(i);
      end

      check("req_ready_idle", req_ready, 1);
      req_valid  = 1'b1;
      req_amount = 9'(amount);
      cycle(1'b1, 1'b0, 0);
      req_valid  = 1'b0;

      if (amount % 5 != 0) begin
         check("bad_amt_fail", fail, 1);
         check("bad_amt_done", done, 0);
         check("bad_amt_eject", eject_valid, 0);
         check("bad_amt_ready", req_ready, 1);
         return;
      end

      for (int c = 0; c < 5; c++) begin
         check("plan_ready", req_ready, 0);
         check("plan_eject", eject_valid, 0);
         check("plan_pulse", {done, fail}, 0);
         cycle(1'b0, 1'b0, 0);
      end

      if (rem != 0) begin
         check("nosplit_fail", fail, 1);
         check("nosplit_done", done, 0);
         check("nosplit_eject", eject_valid, 0);
         check("nosplit_inv", inv_counts, pack_inv());
         return;
      end
      if (amount == 0) begin
         check("zero_done", done, 1);
         check("zero_fail", fail, 0);
         check("zero_eject", eject_valid, 0);
         return;
      end

      foreach (exp_q[k]) begin
         dly = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
         for (int w = 0; w < dly; w++) begin
            check("wait_valid", eject_valid, 1);
            check("wait_sel", eject_sel, exp_q[k]);
            if (noisy) begin
               rand_coin();
               if ($urandom_range(0, 4) == 0) refill = 1'b1;
            end
            cycle(1'b0, 1'b0, 0);
         end
         check("ack_valid", eject_valid, 1);
         check("ack_sel", eject_sel, exp_q[k]);
         eject_ack = 1'b1;
         if (noisy) rand_coin();
         if (force_sel >= 0) begin
            coin_in_vld = 1'b1;
            coin_in_sel = 3'(force_sel);
         end
         cycle(1'b0, 1'b1, exp_q[k]);
         eject_ack = 1'b0;
         check("gap_valid", eject_valid, 0);
         check("gap_done", done, 0);
         if (noisy) begin
            eject_ack = 1'($urandom_range(0, 1));
            rand_coin();
         end
         cycle(1'b0, 1'b0, 0);
         eject_ack = 1'b0;
      end
      check("end_done", done, 1);
      check("end_fail", fail, 0);
      check("end_eject", eject_valid, 0);
      check("end_inv", inv_counts, pack_inv());
   endtask

   initial begin
      int n;
      int amt;

      do_reset();

      run_req(75, 2, 1'b0, -1);
      check("t1_inv_const", inv_counts, 20'h43343);

      run_req(37, 0, 1'b0, -1);
      tick();
      check("t2_fail_once", fail, 0);
      run_req(0, 0, 1'b0, -1);

      run_req(200, 1, 1'b0, -1);
      run_req(200, 0, 1'b0, -1);
      check("t3_rs100_empty", inv_counts[19:16], 0);
      run_req(500, 0, 1'b0, -1);

      refill = 1'b1;
      cycle(1'b1, 1'b0, 0);
      check("refill_inv", inv_counts, 20'hFFFFF);
      run_req(100, 1, 1'b0, 4);
      check("coin_ack_same", inv_counts[19:16], 15);

      for (int r = 0; r < 40; r++) begin
         for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            rand_coin();
            if ($urandom_range(0, 4) == 0) refill = 1'b1;
            cycle(1'b1, 1'b0, 0);
         end
         amt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 511)) : 5 * int'($urandom_range(0, 102));
         run_req(amt, -1, 1'b1, -1);
      end

      // Reset while a coin is being offered aborts silently.
      do_reset();
      req_valid  = 1'b1;
      req_amount = 9'd50;
      cycle(1'b1, 1'b0, 0);
      req_valid  = 1'b0;
      repeat (5) cycle(1'b0, 1'b0, 0);
      check("pre_rst_eject", eject_valid, 1);
      do_reset();
      tick();
      check("post_rst_pulse", {done, fail}, 0);
      check("post_rst_eject", eject_valid, 0);

      for (int i = 0; i < 12; i++) begin
         coin_in_vld = 1'b1;
         coin_in_sel = 3'd0;
         cycle(1'b1, 1'b0, 0);
      end
      check("sat_rs5", inv_counts[3:0], 15);
      for (int s = 5; s < 8; s++) begin
         coin_in_vld = 1'b1;
         coin_in_sel = 3'(s);
         cycle(1'b1, 1'b0, 0);
      end
      check("bad_sel_inv", inv_counts, pack_inv());

      // Ack withheld: the coin is offered for the full timeout, then fault sticks.
      req_valid  = 1'b1;
      req_amount = 9'd50;
      cycle(1'b1, 1'b0, 0);
      req_valid  = 1'b0;
      repeat (5) cycle(1'b0, 1'b0, 0);
      n = 0;
      while (eject_valid === 1'b1 && n < 40) begin
         n++;
         cycle(1'b0, 1'b0, 0);
      end
      check("tmo_wait_cycles", n, 15);
      check("tmo_fault", fault, 1);
      for (int c = 0; c < 3; c++) begin
         req_valid = 1'b1;
         req_amount = 9'd10;
         cycle(1'b0, 1'b0, 0);
         check("fault_sticky", fault, 1);
         check("fault_ready", req_ready, 0);
         check("fault_eject", eject_valid, 0);
         check("fault_pulse", {done, fail}, 0);
      end
      req_valid = 1'b0;
      check("fault_inv", inv_counts, pack_inv());
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
